uart_rx_fsm: RTL and testbench

Serial receiver that consumes the line driven by the team's UART transmitter. It is the downstream counterpart of the TX FSM/PISO path. It oversamples the asynchronous RX line at 16× baud, validates the start bit, and shifts in 8 data bits LSB-first. It checks the optional even-parity bit and the stop bit, then presents the byte with a one-cycle done pulse and error flags to the consuming logic.

---
 rtl/uart_rx_fsm.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// 16x-oversampling UART receiver: 8 data bits LSB-first, optional even parity, one stop bit.
// Define UART_RX_PARITY_EN to receive 11-bit frames with an even-parity check.
module uart_rx_fsm #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       rx_serial_i,
  output logic [7:0] rx_data_o,
  output logic       rx_done_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       rx_busy_o
);

  localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int unsigned TickW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e           state_q;
  logic             sync1_q, sync2_q, prev_q;
  logic [TickW-1:0] tick_cnt_q;
  logic [3:0]       sample_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             done_q;
  logic             frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q;
  logic             parity_err_q;
`endif

  logic sample;
  logic tick;

  assign sample = sync2_q;
  assign tick   = (state_q != StIdle) && (tick_cnt_q == TickMax);

  // Synchronizer and edge-detect flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_serial_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q      <= StIdle;
      tick_cnt_q   <= '0;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      // Divider idles at zero so the first tick lands TICK_DIV cycles after START entry.
      if (state_q == StIdle || tick) begin
        tick_cnt_q <= '0;
      end else begin
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          sample_cnt_q <= '0;
          if (!sample && prev_q) begin
            state_q <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            if (sample_cnt_q == 4'd7) begin
              sample_cnt_q <= '0;
              bit_cnt_q    <= '0;
              state_q      <= sample ? StIdle : StData;
            end else begin
              sample_cnt_q <= sample_cnt_q + 4'd1;
            end
          end
        end
        StData: begin
          if (tick) begin
            if (sample_cnt_q == 4'd15) begin
              sample_cnt_q <= '0;
              shift_q      <= {sample, shift_q[7:1]};
              bit_cnt_q    <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= StParity;
`else
                state_q <= StStop;
`endif
              end
            end else begin
              sample_cnt_q <= sample_cnt_q + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (tick) begin
            if (sample_cnt_q == 4'd15) begin
              sample_cnt_q <= '0;
              par_bad_q    <= sample ^ (^shift_q);
              state_q      <= StStop;
            end else begin
              sample_cnt_q <= sample_cnt_q + 4'd1;
            end
          end
        end
`endif
        StStop: begin
          if (tick) begin
            if (sample_cnt_q == 4'd15) begin
              // Leaving mid stop bit lets a back-to-back start edge be caught.
              sample_cnt_q <= '0;
              data_q       <= shift_q;
              frame_err_q  <= ~sample;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_bad_q;
`endif
              done_q       <= 1'b1;
              state_q      <= StIdle;
            end else begin
              sample_cnt_q <= sample_cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_data_o   = data_q;
  assign rx_done_o   = done_q;
  assign frame_err_o = frame_err_q;
  assign rx_busy_o   = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm at TICK_DIV=10 (160 clk per bit); adapts to UART_RX_PARITY_EN.
module tb_uart_rx_fsm;

  localparam int BitCyc = 160;
`ifdef UART_RX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  // Pin edge to done: 2 sync + edge detect, then 8 ticks to mid start and 16 per later bit.
  localparam int DoneLat = 3 + (8 + 16 * (FrameBits - 1)) * 10;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int done_prev = 0;
  int frame_t0 = 0;
  int cnt_before;

  uart_rx_fsm #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (10_000)
  ) dut (
    .clk_i        (clk),
    .nrst_i       (nrst),
    .rx_serial_i  (rx),
    .rx_data_o    (rx_data),
    .rx_done_o    (rx_done),
    .parity_err_o (parity_err),
    .frame_err_o  (frame_err),
    .rx_busy_o    (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rx_done) begin
      done_cnt  = done_cnt + 1;
      done_prev = done_cyc;
      done_cyc  = cyc;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par_flip, input logic stop_bit);
    rx = 1'b0;
    frame_t0 = cyc;
    wait_cyc(BitCyc);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(BitCyc);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    wait_cyc(BitCyc);
`endif
    rx = stop_bit;
    wait_cyc(BitCyc);
  endtask

  initial begin
    // Reset with idle line
    wait_cyc(5);
    check("rst_data", rx_data, 8'h00);
    check("rst_done", rx_done, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    nrst = 1'b1;
    wait_cyc(20);
    check("post_rst_data", rx_data, 8'h00);
    check("post_rst_busy", rx_busy, 1'b0);

    // Clean 0xA5
    cnt_before = done_cnt;
    send_byte(8'hA5, 1'b0, 1'b1);
    check("a5_done_cnt", done_cnt - cnt_before, 1);
    check("a5_latency", done_cyc - frame_t0, DoneLat);
    check("a5_data", rx_data, 8'hA5);
    check("a5_perr", parity_err, 1'b0);
    check("a5_ferr", frame_err, 1'b0);
    wait_cyc(200);

    // 40-cycle glitch: START entered at +3, abandoned at +83
    cnt_before = done_cnt;
    rx = 1'b0;
    wait_cyc(4);
    check("glitch_busy_hi", rx_busy, 1'b1);
    wait_cyc(36);
    rx = 1'b1;
    wait_cyc(42);
    check("glitch_busy_last", rx_busy, 1'b1);
    wait_cyc(1);
    check("glitch_busy_lo", rx_busy, 1'b0);
    wait_cyc(300);
    check("glitch_no_done", done_cnt - cnt_before, 0);
    check("glitch_data", rx_data, 8'hA5);

`ifdef UART_RX_PARITY_EN
    // 0x3C with inverted parity bit
    cnt_before = done_cnt;
    send_byte(8'h3C, 1'b1, 1'b1);
    check("3c_done_cnt", done_cnt - cnt_before, 1);
    check("3c_data", rx_data, 8'h3C);
    check("3c_perr", parity_err, 1'b1);
    check("3c_ferr", frame_err, 1'b0);
    wait_cyc(200);
`endif

    // 0x81 with stop bit low
    cnt_before = done_cnt;
    send_byte(8'h81, 1'b0, 1'b0);
    rx = 1'b1;
    check("81_done_cnt", done_cnt - cnt_before, 1);
    check("81_data", rx_data, 8'h81);
    check("81_ferr", frame_err, 1'b1);
    check("81_perr", parity_err, 1'b0);
    wait_cyc(200);

    // Clean 0x55 clears flags
    send_byte(8'h55, 1'b0, 1'b1);
    check("55_data", rx_data, 8'h55);
    check("55_ferr", frame_err, 1'b0);
    check("55_perr", parity_err, 1'b0);
    wait_cyc(200);

    // Reset after 3 data bits of 0xF0
    cnt_before = done_cnt;
    rx = 1'b0;
    wait_cyc(BitCyc * 4);
    check("mid_busy", rx_busy, 1'b1);
    nrst = 1'b0;
    #1;
    check("mid_rst_busy", rx_busy, 1'b0);
    check("mid_rst_data", rx_data, 8'h00);
    rx = 1'b1;
    wait_cyc(5);
    nrst = 1'b1;
    wait_cyc(BitCyc * 8);
    check("mid_no_done", done_cnt - cnt_before, 0);
    check("mid_idle", rx_busy, 1'b0);

    send_byte(8'h0F, 1'b0, 1'b1);
    check("0f_done_cnt", done_cnt - cnt_before, 1);
    check("0f_data", rx_data, 8'h0F);
    check("0f_perr", parity_err, 1'b0);
    check("0f_ferr", frame_err, 1'b0);
    wait_cyc(200);

    // Back-to-back frames with no idle gap
    cnt_before = done_cnt;
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(8'h02, 1'b0, 1'b1);
    wait_cyc(50);
    check("b2b_done_cnt", done_cnt - cnt_before, 2);
    check("b2b_gap", done_cyc - done_prev, BitCyc * FrameBits);
    check("b2b_data", rx_data, 8'h02);
    check("b2b_ferr", frame_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
